// File: rtl/durbin_coeff_bank.sv
// Triangular store for Levinson-Durbin coefficient sets of orders 1..MAX_ORDER with a valid/ready unload.
// Optional `define DCB_MAXMAG_EN builds the running max |coeff| tracker on oMaxMag.
module durbin_coeff_bank #(
    parameter int unsigned MAX_ORDER = 12,
    parameter int unsigned COEFF_W   = 12,
    parameter int unsigned ORDER_W   = 4
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic               iEnable,
    input  logic               iClear,
    input  logic               iLoad,
    input  logic [ORDER_W-1:0] iM,
    input  logic [COEFF_W-1:0] iCoeff,
    input  logic               iStart,
    input  logic [ORDER_W-1:0] iBestM,
    input  logic               iReady,
    output logic [COEFF_W-1:0] oCoeff,
    output logic               oValid,
    output logic               oLast,
    output logic               oDone,
    output logic               oError,
    output logic [COEFF_W-1:0] oMaxMag
);

    localparam int unsigned DEPTH  = MAX_ORDER * (MAX_ORDER + 1) / 2;
    localparam int unsigned CNT_W  = $clog2(MAX_ORDER + 1);
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_UNLOAD, S_DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cur_m;
    logic [CNT_W-1:0]   rcnt;
    logic [CNT_W-1:0]   wcnt [MAX_ORDER+1];
    logic [COEFF_W-1:0] mem  [DEPTH];

    logic               load_legal, start_legal, clear_act, load_block;
    logic               wr_en, load_err, start_go, beat;
    logic [CNT_W-1:0]   load_idx, start_idx, rcnt_inc;
    logic [ADDR_W-1:0]  wr_addr, rd_addr_nxt;
    logic [COEFF_W-1:0] rd_data_nxt;

    // Set m starts at word m*(m-1)/2.
    function automatic logic [ADDR_W-1:0] base_of(input logic [CNT_W-1:0] m);
        int unsigned mi;
        mi = 32'(m);
        return ADDR_W'((mi * (mi - 1)) / 2);
    endfunction

    // Request decode, write address and next-beat read with same-cycle write forwarding.
    always_comb begin
        load_legal  = (iM != '0) && (iM <= ORDER_W'(MAX_ORDER));
        start_legal = (iBestM != '0) && (iBestM <= ORDER_W'(MAX_ORDER));
        load_idx    = load_legal ? CNT_W'(iM) : '0;
        start_idx   = start_legal ? CNT_W'(iBestM) : '0;
        rcnt_inc    = rcnt + CNT_W'(1);
        clear_act   = iEnable && iClear && (state != S_UNLOAD);
        load_block  = (state == S_UNLOAD) && (load_idx == cur_m);
        wr_en       = iEnable && iLoad && load_legal && !clear_act && !load_block
                      && (wcnt[load_idx] != load_idx);
        load_err    = iEnable && iLoad && !clear_act && (!load_legal || load_block);
        wr_addr     = base_of(load_idx) + ADDR_W'(wcnt[load_idx]);
        start_go    = iEnable && iStart && start_legal && !clear_act && (state != S_UNLOAD);
        beat        = iEnable && (state == S_UNLOAD) && oValid && iReady;
        rd_addr_nxt = start_go ? base_of(start_idx) : base_of(cur_m) + ADDR_W'(rcnt_inc);
        rd_data_nxt = '0;
        if (wr_en && (wr_addr == rd_addr_nxt)) begin
            rd_data_nxt = iCoeff;
        end else if (rd_addr_nxt < ADDR_W'(DEPTH)) begin
            rd_data_nxt = mem[rd_addr_nxt];
        end
    end

    // Storage, write counters, unload FSM and registered outputs.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state  <= S_IDLE;
            cur_m  <= '0;
            rcnt   <= '0;
            oCoeff <= '0;
            oValid <= 1'b0;
            oLast  <= 1'b0;
            oDone  <= 1'b0;
            oError <= 1'b0;
            for (int unsigned i = 0; i <= MAX_ORDER; i++) wcnt[i] <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (iEnable) begin
            if (clear_act) begin
                state  <= S_IDLE;
                oDone  <= 1'b0;
                oError <= 1'b0;
                for (int unsigned i = 0; i <= MAX_ORDER; i++) wcnt[i] <= '0;
                for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            end else begin
                if (wr_en) begin
                    mem[wr_addr]   <= iCoeff;
                    wcnt[load_idx] <= wcnt[load_idx] + CNT_W'(1);
                end
                if (load_err) oError <= 1'b1;
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start_go) begin
                            state  <= S_UNLOAD;
                            cur_m  <= start_idx;
                            rcnt   <= '0;
                            oCoeff <= rd_data_nxt;
                            oValid <= 1'b1;
                            oLast  <= (start_idx == CNT_W'(1));
                            oDone  <= 1'b0;
                        end else if (iStart) begin
                            // Illegal order: finish immediately with no beats.
                            state  <= S_DONE;
                            oDone  <= 1'b1;
                            oError <= 1'b1;
                        end
                    end
                    S_UNLOAD: begin
                        if (beat) begin
                            if (oLast) begin
                                state  <= S_DONE;
                                oValid <= 1'b0;
                                oLast  <= 1'b0;
                                oDone  <= 1'b1;
                            end else begin
                                rcnt   <= rcnt_inc;
                                oCoeff <= rd_data_nxt;
                                oLast  <= (rcnt_inc == (cur_m - CNT_W'(1)));
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef DCB_MAXMAG_EN
    logic [COEFF_W-1:0] abs_cur;
    logic [COEFF_W-1:0] max_mag;

    // Saturating magnitude of the presented coefficient.
    always_comb begin
        abs_cur = oCoeff;
        if (oCoeff[COEFF_W-1]) begin
            if (oCoeff == {1'b1, {(COEFF_W-1){1'b0}}}) abs_cur = {1'b0, {(COEFF_W-1){1'b1}}};
            else                                       abs_cur = -oCoeff;
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            max_mag <= '0;
        end else if (iEnable) begin
            if (start_go)                         max_mag <= '0;
            else if (beat && (abs_cur > max_mag)) max_mag <= abs_cur;
        end
    end

    assign oMaxMag = max_mag;
`else
    assign oMaxMag = '0;
`endif

endmodule

// File: tb/tb_durbin_coeff_bank.sv
// Scoreboard bench for durbin_coeff_bank: directed loads, expected beats queued, monitor compares on transfer.
module tb_durbin_coeff_bank;

    typedef struct packed {
        logic        last;
        logic [11:0] coeff;
    } beat_t;

    logic        iClock, iReset, iEnable, iClear, iLoad, iStart, iReady;
    logic [3:0]  iM, iBestM;
    logic [11:0] iCoeff;
    logic [11:0] oCoeff, oMaxMag;
    logic        oValid, oLast, oDone, oError;

    int    n_total = 0;
    int    n_pass  = 0;
    int    n_beats = 0;
    beat_t sb[$];

    durbin_coeff_bank dut (
        .iClock (iClock),  .iReset (iReset), .iEnable(iEnable), .iClear(iClear),
        .iLoad  (iLoad),   .iM     (iM),     .iCoeff (iCoeff),  .iStart(iStart),
        .iBestM (iBestM),  .iReady (iReady), .oCoeff (oCoeff),  .oValid(oValid),
        .oLast  (oLast),   .oDone  (oDone),  .oError (oError),  .oMaxMag(oMaxMag)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Monitor: compare each transferred beat, and the held beat while stalled.
    always @(negedge iClock) begin
        if (!iReset && oValid) begin
            if (sb.size() == 0) begin
                check("spurious_beat", {20'd0, oLast, oCoeff}, 32'hFFFF_FFFF);
            end else if (iReady) begin
                beat_t e;
                e = sb.pop_front();
                n_beats++;
                check("beat", {19'd0, oLast, oCoeff}, {19'd0, e.last, e.coeff});
            end else begin
                check("stall_hold", {19'd0, oLast, oCoeff}, {19'd0, sb[0].last, sb[0].coeff});
            end
        end
    end

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic do_reset();
        iReset = 1'b1;
        tick();
        tick();
        iReset = 1'b0;
    endtask

    task automatic load(input int m, input int c);
        iLoad  = 1'b1;
        iM     = 4'(m);
        iCoeff = 12'(c);
        tick();
        iLoad  = 1'b0;
    endtask

    task automatic push(input int c, input bit last);
        beat_t b;
        b.coeff = 12'(c);
        b.last  = last;
        sb.push_back(b);
    endtask

    task automatic start(input int m, input logic rdy);
        iStart = 1'b1;
        iBestM = 4'(m);
        tick();
        iStart = 1'b0;
        iReady = rdy;
    endtask

    // Drive iReady from pat until oDone; report cycles taken and queue drain.
    task automatic wait_done(input logic [3:0] pat, input string name, input int exp_cycles);
        int cyc;
        bit done;
        cyc  = 0;
        done = 1'b0;
        while (cyc < 80 && !done) begin
            iReady = pat[cyc[1:0]];
            tick();
            cyc++;
            if (oDone) done = 1'b1;
        end
        check({name, "_done"}, 32'(done), 32'd1);
        if (exp_cycles > 0) check({name, "_cycles"}, 32'(cyc), 32'(exp_cycles));
        check({name, "_drained"}, 32'(sb.size()), 32'd0);
        iReady = 1'b1;
    endtask

    initial begin
        iReset = 1'b0; iEnable = 1'b1; iClear = 1'b0; iLoad = 1'b0; iStart = 1'b0;
        iReady = 1'b1; iM = '0; iBestM = '0; iCoeff = '0;
        do_reset();
        check("reset_outputs", {oValid, oLast, oDone, oError, oCoeff, oMaxMag}, 32'd0);

        // Order 3: 5,-7,9 with oDone in the cycle after the last beat.
        load(3, 5); load(3, -7); load(3, 9);
        push(5, 0); push(-7, 0); push(9, 1);
        start(3, 1'b1);
        wait_done(4'b1111, "t1", 3);
        check("t1_valid_low", 32'(oValid), 32'd0);

        // All orders interleaved, value 16*m+k.
        do_reset();
        for (int k = 0; k < 12; k++)
            for (int m = k + 1; m <= 12; m++) load(m, 16 * m + k);
        for (int k = 0; k < 12; k++) push(192 + k, k == 11);
        start(12, 1'b1);
        wait_done(4'b1111, "t2_o12", 12);
        push(16, 1);
        start(1, 1'b1);
        wait_done(4'b1111, "t2_o1", 1);
        check("t2_no_error", 32'(oError), 32'd0);

        // Order 4 under ready pattern 1,0,0,1.
        n_beats = 0;
        for (int k = 0; k < 4; k++) push(64 + k, k == 3);
        start(4, 1'b1);
        wait_done(4'b1001, "t3", 8);
        check("t3_transfers", 32'(n_beats), 32'd4);

        // Illegal unload orders.
        start(0, 1'b1);
        check("t4_o0_flags", {29'd0, oValid, oDone, oError}, 32'b011);
        iClear = 1'b1; tick(); iClear = 1'b0;
        check("t4_clear", {30'd0, oDone, oError}, 32'd0);
        start(13, 1'b1);
        check("t4_o13_flags", {29'd0, oValid, oDone, oError}, 32'b011);
        iClear = 1'b1; tick(); iClear = 1'b0;
        check("t4_clear2", {30'd0, oDone, oError}, 32'd0);

        // Saturating order-2 writes are silent; the cleared store reads zero past written words.
        load(2, 1); load(2, 2); load(2, 3); load(2, 4);
        check("t5_sat_no_error", 32'(oError), 32'd0);
        push(1, 0); push(2, 1);
        start(2, 1'b1);
        wait_done(4'b1111, "t5_o2", 2);
        load(5, 50); load(5, 51); load(5, 52);
        push(50, 0); push(51, 0); push(52, 0); push(0, 0); push(0, 1);
        start(5, 1'b0);
        load(5, 99);
        check("t5_load_during_unload_err", 32'(oError), 32'd1);
        load(6, 60);
        wait_done(4'b1111, "t5_o5", 5);
        push(60, 0);
        for (int k = 1; k < 6; k++) push(0, k == 5);
        start(6, 1'b1);
        wait_done(4'b1111, "t5_o6", 6);

        // Reset while stalled mid-unload, then the set must read back as zeros.
        push(60, 0);
        start(6, 1'b0);
        tick();
        iReset = 1'b1;
        tick();
        check("t5_reset_mid_unload", {oValid, oLast, oDone, oError, oCoeff, oMaxMag}, 32'd0);
        iReset = 1'b0;
        sb.delete();
        for (int k = 0; k < 6; k++) push(0, k == 5);
        start(6, 1'b1);
        wait_done(4'b1111, "t5_zeroed", 6);

        // Max magnitude, with the last load coinciding with iStart.
        load(3, -2048); load(3, 100);
        push(-2048, 0); push(100, 0); push(3, 1);
        iLoad = 1'b1; iM = 4'd3; iCoeff = 12'd3;
        start(3, 1'b1);
        iLoad = 1'b0;
        wait_done(4'b1111, "t6", 3);
`ifdef DCB_MAXMAG_EN
        check("t6_maxmag", 32'(oMaxMag), 32'd2047);
`else
        check("t6_maxmag", 32'(oMaxMag), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
